// File: rtl/serial_pkg.sv
// ============================================================================
// Module   : serial_pkg
// Brief    : Shared types and constants for the serial transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Total clock cycles from the start-bit edge to the end of the last stop bit.
    function automatic int frame_len(input int cpb, input int data_bits,
                                     input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * cpb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bit_timer.sv
// ============================================================================
// Module   : serial_bit_timer
// Brief    : Free-running bit-period counter with clear and end-of-bit pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign bit_done = (cnt_q == TIMER_LAST);

    // Wrapping at the bit boundary keeps back-to-back bits aligned without a gap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module   : serial_tx
// Brief    : UART-style transmitter, LSB-first start/data/parity/stop frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;

    logic                 w_bit_done;
    logic                 w_last_stop;
    logic                 w_accept;

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == ST_IDLE),
        .bit_done (w_bit_done)
    );

    // Opening the handshake in the last stop cycle gives zero-gap back-to-back frames.
    assign w_last_stop = (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP) && w_bit_done;
    assign tx_ready    = (state_q == ST_IDLE) || w_last_stop;
    assign w_accept    = tx_valid && tx_ready;
    assign busy        = (state_q != ST_IDLE);
    assign tx          = tx_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
            end
            ST_START: begin
                if (w_bit_done) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // Parity is fixed at accept so later tx_data changes cannot leak into the frame.
        if (w_accept) begin
            state_d   = ST_START;
            shift_d   = tx_data;
            bit_cnt_d = '0;
            parity_d  = (PARITY == PARITY_ODD) ? ~(^tx_data) : (^tx_data);
        end

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// Module   : tb_serial_tx
// Brief    : Directed self-checking bench for serial_tx in four configurations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx;

    localparam int NDUT = 4;
    localparam int CPB  = 4;

    // Instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    function automatic int par_of(input int k);
        case (k)
            1:       return 1;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int k);
        return (k == 3) ? 2 : 1;
    endfunction

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data  [NDUT];
    logic       tx_valid [NDUT];
    logic       tx_o     [NDUT];
    logic       busy_o   [NDUT];
    logic       ready_o  [NDUT];

    int n_checks = 0;
    int n_err    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        serial_tx #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY       (par_of(g)),
            .STOP_BITS    (stop_of(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (ready_o[g]),
            .tx       (tx_o[g]),
            .busy     (busy_o[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] w;
        int         len;
        logic       par;
    } vec_t;

    // Sends one word on instance k and checks tx/busy/tx_ready every cycle of the frame.
    task automatic run_frame(input int k, input logic [7:0] w, input int len, input logic par);
        logic lvl [16];
        int   nb;
        nb = 0;
        lvl[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            lvl[nb] = w[i]; nb++;
        end
        if (par_of(k) != 0) begin
            lvl[nb] = par; nb++;
        end
        for (int s = 0; s < stop_of(k); s++) begin
            lvl[nb] = 1'b1; nb++;
        end
        for (int i = nb; i < 16; i++) lvl[i] = 1'b1;

        chk($sformatf("u%0d w=%h ready before", k, w), 32'(ready_o[k]), 32'd1);
        tx_data[k]  = w;
        tx_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid[k] = 1'b0;
        for (int c = 0; c < len; c++) begin
            chk($sformatf("u%0d w=%h tx c=%0d", k, w, c), 32'(tx_o[k]), 32'(lvl[c / CPB]));
            chk($sformatf("u%0d w=%h busy c=%0d", k, w, c), 32'(busy_o[k]), 32'd1);
            chk($sformatf("u%0d w=%h ready c=%0d", k, w, c), 32'(ready_o[k]),
                (c == len - 1) ? 32'd1 : 32'd0);
            tx_data[k] = 8'($urandom);
            @(negedge clk);
        end
        chk($sformatf("u%0d w=%h tx after", k, w), 32'(tx_o[k]), 32'd1);
        chk($sformatf("u%0d w=%h busy after", k, w), 32'(busy_o[k]), 32'd0);
        chk($sformatf("u%0d w=%h ready after", k, w), 32'(ready_o[k]), 32'd1);
    endtask

    initial begin
        vec_t vecs [6];
        int   bad;
        logic b2b_lvl [20];

        vecs[0] = '{k: 0, w: 8'hA5, len: 40, par: 1'b0};
        vecs[1] = '{k: 1, w: 8'h07, len: 44, par: 1'b1};
        vecs[2] = '{k: 2, w: 8'h07, len: 44, par: 1'b0};
        vecs[3] = '{k: 3, w: 8'hA5, len: 44, par: 1'b0};
        vecs[4] = '{k: 1, w: 8'hA5, len: 44, par: 1'b0};
        vecs[5] = '{k: 2, w: 8'h3C, len: 44, par: 1'b1};

        rst_n = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("u%0d reset tx", k), 32'(tx_o[k]), 32'd1);
            chk($sformatf("u%0d reset busy", k), 32'(busy_o[k]), 32'd0);
            chk($sformatf("u%0d reset ready", k), 32'(ready_o[k]), 32'd1);
        end
        rst_n = 1'b1;

        // Long idle with data wiggling but no valid
        for (int k = 0; k < NDUT; k++) begin
            bad = 0;
            if (k == 0) begin
                for (int c = 0; c < 1000; c++) begin
                    for (int j = 0; j < NDUT; j++) tx_data[j] = 8'($urandom);
                    @(negedge clk);
                    for (int j = 0; j < NDUT; j++) begin
                        if (tx_o[j] !== 1'b1 || busy_o[j] !== 1'b0 || ready_o[j] !== 1'b1)
                            bad++;
                    end
                end
            end
            chk("idle 1000 cycles bad count", 32'(bad), 32'd0);
        end

        foreach (vecs[i]) begin
            run_frame(vecs[i].k, vecs[i].w, vecs[i].len, vecs[i].par);
        end

        // Back-to-back 8'h00 then 8'hFF with tx_valid held
        b2b_lvl[0] = 1'b0;
        for (int i = 1; i < 9; i++)  b2b_lvl[i] = 1'b0;
        b2b_lvl[9] = 1'b1;
        b2b_lvl[10] = 1'b0;
        for (int i = 11; i < 19; i++) b2b_lvl[i] = 1'b1;
        b2b_lvl[19] = 1'b1;
        chk("b2b ready before", 32'(ready_o[0]), 32'd1);
        tx_data[0]  = 8'h00;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data[0] = 8'hFF;
        for (int c = 0; c < 80; c++) begin
            chk($sformatf("b2b tx c=%0d", c), 32'(tx_o[0]), 32'(b2b_lvl[c / CPB]));
            if (c == 39) chk("b2b ready final stop", 32'(ready_o[0]), 32'd1);
            if (c == 38) chk("b2b ready early", 32'(ready_o[0]), 32'd0);
            if (c == 40) tx_valid[0] = 1'b0;
            @(negedge clk);
        end
        chk("b2b tx idle", 32'(tx_o[0]), 32'd1);
        chk("b2b busy idle", 32'(busy_o[0]), 32'd0);

        // Reset 13 cycles into an 8'h3C frame
        tx_data[0]  = 8'h3C;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        for (int c = 0; c < 13; c++) @(negedge clk);
        chk("pre-reset busy", 32'(busy_o[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset tx", 32'(tx_o[0]), 32'd1);
        chk("async reset busy", 32'(busy_o[0]), 32'd0);
        chk("async reset ready", 32'(ready_o[0]), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0) bad++;
        end
        chk("post-reset idle bad count", 32'(bad), 32'd0);
        run_frame(0, 8'h81, 40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
